adc_conv_scheduler: RTL and testbench

//  Sequences the successive-approximation ADC core at a fixed sample rate.
//  On each sample tick it issues a burst of 2^OSR_LOG2 conversions and averages them.
//  It presents the result on a valid/ready stream to downstream audio logic.
//  It flags overruns and conversion timeouts. Sits between the SAR core (start/done) and the audio datapath.

---
 rtl/adc_conv_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_adc_conv_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_conv_scheduler.sv
// -----------------------------------------------------------------------------
// adc_conv_scheduler
// Schedules a successive-approximation ADC core at a fixed sample rate. Each
// sample tick starts a burst of 2^OSR_LOG2 conversions. The results are summed
// and the truncated average is presented on a valid/ready stream.
//
// Ports
//   clk_i          : clock
//   reset_ni       : asynchronous active-low reset
//   enable_i       : run the tick counter and schedule bursts
//   conv_start_o   : one-cycle pulse, SAR core begins one conversion
//   conv_done_i    : one-cycle pulse, conv_data_i is valid
//   conv_data_i    : conversion result
//   sample_o       : averaged sample
//   sample_valid_o : sample_o valid, held until accepted
//   sample_ready_i : downstream accepts when valid & ready
//   busy_o         : burst in progress
//   overrun_o      : sticky, a sample was overwritten or a tick was missed
//   timeout_o      : sticky, a conversion timed out
//   clr_flags_i    : clears overrun_o and timeout_o (a same-cycle set wins)
// -----------------------------------------------------------------------------
module adc_conv_scheduler #(
    parameter int DATA_W   = 14,
    parameter int CLK_DIV  = 1500,
    parameter int OSR_LOG2 = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              enable_i,
    output logic              conv_start_o,
    input  logic              conv_done_i,
    input  logic [DATA_W-1:0] conv_data_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              busy_o,
    output logic              overrun_o,
    output logic              timeout_o,
    input  logic              clr_flags_i
);

    localparam int ACC_W  = DATA_W + OSR_LOG2;
    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CNT_W  = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;

    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(CLK_DIV - 1);
    localparam logic [WDOG_W-1:0] WDOG_LOAD   = WDOG_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'((1 << OSR_LOG2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    // Truncating average: dropping the OSR_LOG2 low bits divides the sum by
    // the number of conversions in the burst.
    function automatic logic [DATA_W-1:0] acc_average(input logic [ACC_W-1:0] acc);
        return acc[ACC_W-1:OSR_LOG2];
    endfunction

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;
    logic                conv_start_q, conv_start_d;
    logic                busy_q, busy_d;

    logic                tick_s;
    logic                load_s;
    logic                timeout_set_s;
    logic                overrun_set_s;

    // Sample-rate tick counter: held at reload while disabled.
    always_comb begin
        tick_s     = enable_i && (tick_cnt_q == '0);
        tick_cnt_d = tick_cnt_q;
        if (!enable_i) begin
            tick_cnt_d = TICK_RELOAD;
        end else if (tick_s) begin
            tick_cnt_d = TICK_RELOAD;
        end else begin
            tick_cnt_d = tick_cnt_q - TICK_W'(1);
        end
    end

    // Burst sequencer: next state, accumulator, conversion count, watchdog.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        wdog_d        = wdog_q;
        load_s        = 1'b0;
        timeout_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    state_d = ST_START;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                wdog_d  = WDOG_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (conv_done_i) begin
                    acc_d = acc_q + ACC_W'(conv_data_i);
                    // A burst interrupted by enable_i is abandoned once the
                    // conversion already in flight has returned.
                    if (!enable_i) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_OUTPUT;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_START;
                    end
                end else if (wdog_q == '0) begin
                    timeout_set_s = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wdog_d = wdog_q - WDOG_W'(1);
                end
            end
            ST_OUTPUT: begin
                load_s  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage and sticky flags; set events take priority over clear.
    always_comb begin
        sample_d      = sample_q;
        valid_d       = valid_q;
        overrun_set_s = (tick_s && (state_q != ST_IDLE)) ||
                        (load_s && valid_q && !sample_ready_i);
        if (load_s) begin
            sample_d = acc_average(acc_q);
            valid_d  = 1'b1;
        end else if (valid_q && sample_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (overrun_set_s) begin
            overrun_d = 1'b1;
        end else if (clr_flags_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (timeout_set_s) begin
            timeout_d = 1'b1;
        end else if (clr_flags_i) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end

        conv_start_d = (state_d == ST_START);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= TICK_RELOAD;
            acc_q        <= '0;
            cnt_q        <= '0;
            wdog_q       <= '0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            wdog_q       <= wdog_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            conv_start_q <= conv_start_d;
            busy_q       <= busy_d;
        end
    end

    assign conv_start_o   = conv_start_q;
    assign busy_o         = busy_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign overrun_o      = overrun_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adc_conv_scheduler
// Self-checking bench for adc_conv_scheduler (CLK_DIV=100, OSR_LOG2=2,
// TIMEOUT=50). An ADC model answers each conv_start_o after a programmable
// latency and pushes the expected average of every full burst to a queue;
// a monitor pops and compares each accepted sample.
// -----------------------------------------------------------------------------
module tb_adc_conv_scheduler;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        enable_i;
    logic        conv_start_o;
    logic        conv_done_i;
    logic [13:0] conv_data_i;
    logic [13:0] sample_o;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic        busy_o;
    logic        overrun_o;
    logic        timeout_o;
    logic        clr_flags_i;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] exp_q[$];
    logic [13:0] mon_e;
    logic [13:0] last_sample = 14'h0;
    int          n_acc = 0;
    int          n_start = 0;
    int          n_done = 0;
    int          adc_lat = 20;
    bit          adc_mute = 1'b0;
    int          adc_pos = 0;
    int          adc_sum = 0;
    int          burst_no = 0;

    adc_conv_scheduler #(
        .DATA_W  (14),
        .CLK_DIV (100),
        .OSR_LOG2(2),
        .TIMEOUT (50)
    ) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .enable_i      (enable_i),
        .conv_start_o  (conv_start_o),
        .conv_done_i   (conv_done_i),
        .conv_data_i   (conv_data_i),
        .sample_o      (sample_o),
        .sample_valid_o(sample_valid_o),
        .sample_ready_i(sample_ready_i),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o),
        .timeout_o     (timeout_o),
        .clr_flags_i   (clr_flags_i)
    );

    always #5 clk_i = ~clk_i;

    // ADC model: answers a start pulse adc_lat cycles later. Burst 0 returns
    // 0x1000..0x1003; later bursts vary base and step.
    initial begin : adc_model
        bit          skip;
        int          cur_pos;
        logic [13:0] d;
        skip = 1'b0;
        forever begin
            if (!skip) @(negedge clk_i);
            skip = 1'b0;
            if (conv_start_o && reset_ni) begin
                n_start++;
                cur_pos = adc_pos;
                adc_pos = (adc_pos == 3) ? 0 : adc_pos + 1;
                if (cur_pos == 0) adc_sum = 0;
                d = 14'(32'h1000 + cur_pos * (1 + burst_no % 3) + burst_no * 37);
                if (!adc_mute) begin
                    repeat (adc_lat) @(negedge clk_i);
                    conv_data_i = d;
                    conv_done_i = 1'b1;
                    n_done++;
                    adc_sum += int'(d);
                    if (cur_pos == 3) begin
                        exp_q.push_back(14'(adc_sum / 4));
                        burst_no++;
                    end
                    @(negedge clk_i);
                    conv_done_i = 1'b0;
                    skip = 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor: compares every accepted sample with the queue head.
    always @(negedge clk_i) begin
        #2;
        if (reset_ni && sample_valid_o && sample_ready_i) begin
            n_acc++;
            last_sample = sample_o;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: sample_o=%0h accepted with no expected entry", sample_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (sample_o !== mon_e) begin
                    errors++;
                    $display("FAIL sb_sample: got %0h expected %0h", sample_o, mon_e);
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got %0d checks expected completion", checks);
        $fatal(1, "time limit");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_start(input int max, output int k, output bit found);
        found = 1'b0;
        k = 0;
        while (k < max && !found) begin
            @(negedge clk_i);
            k++;
            if (conv_start_o) found = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({conv_start_o, sample_valid_o, busy_o, overrun_o, timeout_o} !== 5'b0) begin
            errors++;
            $display("FAIL %s_flags: got %b expected 00000", name,
                     {conv_start_o, sample_valid_o, busy_o, overrun_o, timeout_o});
        end
        checks++;
        if (sample_o !== 14'h0) begin
            errors++;
            $display("FAIL %s_sample: got %0h expected 0", name, sample_o);
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; enable_i = 1'b0; conv_done_i = 1'b0; conv_data_i = 14'h0;
        sample_ready_i = 1'b1; clr_flags_i = 1'b0;
        wait_cycles(3);
        check_all_zero("reset");
        reset_ni = 1'b1;
        wait_cycles(2);
        check_all_zero("post_reset");
    endtask

    task automatic test_basic();
        int n0, s0;
        adc_pos = 0; adc_lat = 20; sample_ready_i = 1'b1;
        n0 = n_acc; s0 = n_start;
        enable_i = 1'b1;
        wait_cycles(190);
        checks++;
        if (n_acc - n0 != 1) begin errors++; $display("FAIL basic_first_count: got %0d expected 1", n_acc - n0); end
        checks++;
        if (last_sample !== 14'h1001) begin errors++; $display("FAIL basic_first_value: got %0h expected 1001", last_sample); end
        wait_cycles(300);
        checks++;
        if (n_acc - n0 != 4) begin errors++; $display("FAIL basic_rate: got %0d samples expected 4", n_acc - n0); end
        checks++;
        if (n_start - s0 != 16) begin errors++; $display("FAIL basic_starts: got %0d expected 16", n_start - s0); end
        checks++;
        if ({overrun_o, timeout_o} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b expected 00", {overrun_o, timeout_o}); end
        enable_i = 1'b0;
        wait_cycles(60);
    endtask

    task automatic test_backpressure();
        int n0;
        adc_pos = 0; sample_ready_i = 1'b0;
        n0 = n_acc;
        enable_i = 1'b1;
        wait_cycles(300);
        checks++;
        if (sample_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b expected 1", sample_valid_o); end
        checks++;
        if (overrun_o !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b expected 1", overrun_o); end
        checks++;
        if (exp_q.size() != 2) begin
            errors++; $display("FAIL bp_queue: got %0d entries expected 2", exp_q.size());
        end else begin
            checks++;
            if (sample_o !== exp_q[1]) begin errors++; $display("FAIL bp_overwrite: got %0h expected %0h", sample_o, exp_q[1]); end
        end
        // The first sample was overwritten and never delivered.
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        sample_ready_i = 1'b1;
        wait_cycles(3);
        checks++;
        if (n_acc - n0 != 1 || sample_valid_o !== 1'b0) begin
            errors++; $display("FAIL bp_accept: got count %0d valid %b expected 1 and 0", n_acc - n0, sample_valid_o);
        end
        clr_flags_i = 1'b1;
        wait_cycles(1);
        clr_flags_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b0) begin errors++; $display("FAIL bp_clear: got %b expected 0", overrun_o); end
        enable_i = 1'b0;
        wait_cycles(60);
    endtask

    task automatic test_timeout();
        int k, n0;
        bit found;
        adc_pos = 0; adc_mute = 1'b1;
        n0 = n_acc;
        enable_i = 1'b1;
        wait_start(150, k, found);
        checks++;
        if (!found) begin errors++; $display("FAIL to_first_start: got none expected start within 150"); end
        // Watchdog loads 50 in START, counts 50..0 in WAIT, flag lands 52 cycles after the start cycle.
        wait_cycles(51);
        checks++;
        if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", timeout_o); end
        wait_cycles(1);
        checks++;
        if (timeout_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("FAIL to_flag: got timeout %b busy %b expected 1 0", timeout_o, busy_o);
        end
        wait_start(120, k, found);
        checks++;
        if (!found || k != 48) begin errors++; $display("FAIL to_restart: got found %b after %0d expected 1 after 48", found, k); end
        checks++;
        if (n_acc != n0 || sample_valid_o !== 1'b0) begin
            errors++; $display("FAIL to_no_output: got %0d samples valid %b expected 0 0", n_acc - n0, sample_valid_o);
        end
        enable_i = 1'b0;
        wait_cycles(60);
        clr_flags_i = 1'b1;
        wait_cycles(1);
        clr_flags_i = 1'b0;
        checks++;
        if ({overrun_o, timeout_o} !== 2'b00) begin errors++; $display("FAIL to_clear: got %b expected 00", {overrun_o, timeout_o}); end
        adc_mute = 1'b0;
    endtask

    task automatic test_slow_adc();
        int n0;
        adc_pos = 0; adc_lat = 30; sample_ready_i = 1'b1;
        n0 = n_acc;
        enable_i = 1'b1;
        wait_cycles(430);
        checks++;
        if (n_acc - n0 != 2) begin errors++; $display("FAIL slow_count: got %0d expected 2", n_acc - n0); end
        checks++;
        if ({overrun_o, timeout_o} !== 2'b10) begin errors++; $display("FAIL slow_flags: got %b expected 10", {overrun_o, timeout_o}); end
        enable_i = 1'b0;
        wait_cycles(20);
        clr_flags_i = 1'b1;
        wait_cycles(1);
        clr_flags_i = 1'b0;
        adc_lat = 20;
    endtask

    task automatic test_enable_drop();
        int k, n0, d0;
        bit found;
        adc_pos = 0; sample_ready_i = 1'b1;
        n0 = n_acc; d0 = n_done;
        enable_i = 1'b1;
        wait_start(150, k, found);
        wait_start(40, k, found);
        checks++;
        if (!found) begin errors++; $display("FAIL drop_second_start: got none expected start within 40"); end
        enable_i = 1'b0;
        wait_cycles(10);
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL drop_awaits: got busy %b expected 1", busy_o); end
        wait_cycles(15);
        checks++;
        if (busy_o !== 1'b0 || sample_valid_o !== 1'b0 || n_acc != n0 || n_done - d0 != 2) begin
            errors++;
            $display("FAIL drop_discard: got busy %b valid %b samples %0d dones %0d expected 0 0 0 2",
                     busy_o, sample_valid_o, n_acc - n0, n_done - d0);
        end
        wait_cycles(20);
        adc_pos = 0;
        enable_i = 1'b1;
        wait_start(150, k, found);
        checks++;
        if (!found || k != 100) begin errors++; $display("FAIL drop_reenable: got found %b after %0d expected 1 after 100", found, k); end
        wait_cycles(100);
        checks++;
        if (n_acc - n0 != 1) begin errors++; $display("FAIL drop_resume: got %0d samples expected 1", n_acc - n0); end
        enable_i = 1'b0;
        wait_cycles(20);
    endtask

    task automatic test_async_reset();
        int k, n0;
        bit found;
        adc_pos = 0; sample_ready_i = 1'b0;
        enable_i = 1'b1;
        k = 0;
        while (k < 300 && sample_valid_o !== 1'b1) begin
            @(negedge clk_i);
            k++;
        end
        checks++;
        if (sample_valid_o !== 1'b1) begin errors++; $display("FAIL ar_valid: got %b expected 1", sample_valid_o); end
        wait_start(40, k, found);
        wait_cycles(5);
        checks++;
        if (busy_o !== 1'b1 || sample_valid_o !== 1'b1) begin
            errors++; $display("FAIL ar_pre: got busy %b valid %b expected 1 1", busy_o, sample_valid_o);
        end
        reset_ni = 1'b0;
        #1;
        check_all_zero("ar_immediate");
        wait_cycles(30);
        exp_q.delete();
        adc_pos = 0;
        sample_ready_i = 1'b1;
        n0 = n_acc;
        reset_ni = 1'b1;
        wait_cycles(190);
        checks++;
        if (n_acc - n0 != 1) begin errors++; $display("FAIL ar_resume: got %0d samples expected 1", n_acc - n0); end
        checks++;
        if ({overrun_o, timeout_o} !== 2'b00) begin errors++; $display("FAIL ar_flags: got %b expected 00", {overrun_o, timeout_o}); end
        enable_i = 1'b0;
        wait_cycles(40);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_slow_adc();
        test_enable_drop();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
